// File: rtl/prime_check.sv
// Trial-division primality responder on the go/ready/error handshake.
// Uses repeated subtraction only, so it needs no multiplier or divider.
module prime_check #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_go,
  input  logic [WIDTH-1:0] i_n,
  output logic             o_ready,
  output logic             o_error,
  output logic             o_is_prime,
  output logic [WIDTH-1:0] o_factor
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_CHECK,
    S_DIV,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_nr;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH+1:0] r_sq;

  logic [WIDTH+1:0] w_nrExt;
  logic [WIDTH+1:0] w_sqNext;

  // Two guard bits keep d*d from wrapping before it exceeds the largest n.
  assign w_nrExt  = {2'b00, r_nr};
  assign w_sqNext = r_sq + {1'b0, r_d, 1'b0} + (WIDTH+2)'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      o_ready    <= 1'b1;
      o_error    <= 1'b0;
      o_is_prime <= 1'b0;
      o_factor   <= '0;
      r_nr       <= '0;
      r_d        <= '0;
      r_rem      <= '0;
      r_sq       <= '0;
    end else begin
      if (i_go && !o_ready) begin
        o_error <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_go && !o_error) begin
            r_nr    <= i_n;
            o_ready <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (r_nr < WIDTH'(2)) begin
            o_is_prime <= 1'b0;
            o_factor   <= '0;
            r_state    <= S_DONE;
          end else begin
            r_d     <= WIDTH'(2);
            r_sq    <= (WIDTH+2)'(4);
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (r_sq > w_nrExt) begin
            o_is_prime <= 1'b1;
            o_factor   <= r_nr;
            r_state    <= S_DONE;
          end else begin
            r_rem   <= r_nr;
            r_state <= S_DIV;
          end
        end

        // One subtraction per cycle; a zero remainder means d divides n.
        S_DIV: begin
          if (r_rem >= r_d) begin
            r_rem <= r_rem - r_d;
          end else if (r_rem == '0) begin
            o_is_prime <= 1'b0;
            o_factor   <= r_d;
            r_state    <= S_DONE;
          end else begin
            r_d     <= r_d + WIDTH'(1);
            r_sq    <= w_sqNext;
            r_state <= S_CHECK;
          end
        end

        S_DONE: begin
          o_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          o_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_check.sv
// Scoreboard bench for prime_check: a 16-bit instance for the main cases
// and an 8-bit instance to reach the top-of-range boundary in few cycles.
module tb_prime_check;

  typedef struct {
    logic        isPrime;
    logic [31:0] factor;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        goA = 1'b0;
  logic [15:0] nA  = '0;
  logic        goB = 1'b0;
  logic [7:0]  nB  = '0;

  logic        readyA, errorA, primeA;
  logic [15:0] factorA;
  logic        readyB, errorB, primeB;
  logic [7:0]  factorB;

  int   checks = 0;
  int   errors = 0;
  exp_t sbQ[$];

  always #5 clk = ~clk;

  prime_check #(.WIDTH(16)) u_dutA (
    .i_clk(clk), .i_rst(rst), .i_go(goA), .i_n(nA),
    .o_ready(readyA), .o_error(errorA), .o_is_prime(primeA), .o_factor(factorA)
  );

  prime_check #(.WIDTH(8)) u_dutB (
    .i_clk(clk), .i_rst(rst), .i_go(goB), .i_n(nB),
    .o_ready(readyB), .o_error(errorB), .o_is_prime(primeB), .o_factor(factorB)
  );

  // Reference: plain trial division with the modulo operator.
  function automatic exp_t refModel(input int unsigned nv);
    exp_t r;
    r.isPrime = 1'b0;
    r.factor  = 32'd0;
    if (nv >= 2) begin
      r.isPrime = 1'b1;
      r.factor  = nv;
      for (int unsigned d = 2; d * d <= nv; d++) begin
        if (nv % d == 0) begin
          r.isPrime = 1'b0;
          r.factor  = d;
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic logic obsReady(input int sel);
    return (sel == 0) ? readyA : readyB;
  endfunction

  function automatic logic obsPrime(input int sel);
    return (sel == 0) ? primeA : primeB;
  endfunction

  function automatic logic [31:0] obsFactor(input int sel);
    return (sel == 0) ? {16'd0, factorA} : {24'd0, factorB};
  endfunction

  task automatic doCheck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input int unsigned nv);
    @(negedge clk);
    if (sel == 0) begin
      goA = 1'b1;
      nA  = nv[15:0];
    end else begin
      goB = 1'b1;
      nB  = nv[7:0];
    end
    sbQ.push_back(refModel(nv));
    @(negedge clk);
    goA = 1'b0;
    goB = 1'b0;
  endtask

  task automatic checkOutput(input int sel, input string tag, output int waited);
    exp_t e;
    waited = 0;
    while (!obsReady(sel) && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    doCheck({tag, "_ready"}, {31'd0, obsReady(sel)}, 32'd1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      doCheck({tag, "_prime"},  {31'd0, obsPrime(sel)}, {31'd0, e.isPrime});
      doCheck({tag, "_factor"}, obsFactor(sel), e.factor);
    end else begin
      doCheck({tag, "_sb_empty"}, sbQ.size(), 32'd1);
    end
  endtask

  initial begin
    int waited;

    $display("[TB] reset");
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    doCheck("rst_ready",  {31'd0, readyA}, 32'd1);
    doCheck("rst_error",  {31'd0, errorA}, 32'd0);
    doCheck("rst_prime",  {31'd0, primeA}, 32'd0);
    doCheck("rst_factor", {16'd0, factorA}, 32'd0);

    $display("[TB] n=0 latency");
    applyStimulus(0, 0);
    doCheck("n0_busy", {31'd0, readyA}, 32'd0);
    checkOutput(0, "n0", waited);
    doCheck("n0_latency", waited, 32'd2);
    doCheck("n0_error", {31'd0, errorA}, 32'd0);

    $display("[TB] directed values");
    applyStimulus(0, 2);
    checkOutput(0, "n2", waited);
    applyStimulus(0, 97);
    checkOutput(0, "n97", waited);
    applyStimulus(0, 91);
    checkOutput(0, "n91", waited);
    applyStimulus(0, 4);
    checkOutput(0, "n4", waited);
    applyStimulus(0, 3);
    checkOutput(0, "n3", waited);
    applyStimulus(0, 1);
    checkOutput(0, "n1", waited);

    $display("[TB] top of range on 8-bit instance");
    applyStimulus(1, 251);
    checkOutput(1, "b251", waited);
    applyStimulus(1, 255);
    checkOutput(1, "b255", waited);
    applyStimulus(1, 169);
    checkOutput(1, "b169", waited);
    doCheck("b_error", {31'd0, errorB}, 32'd0);

    $display("[TB] protocol violation");
    applyStimulus(0, 91);
    goA = 1'b1;
    nA  = 16'd5;
    @(negedge clk);
    goA = 1'b0;
    doCheck("viol_error", {31'd0, errorA}, 32'd1);
    checkOutput(0, "viol91", waited);
    doCheck("viol_sticky", {31'd0, errorA}, 32'd1);
    goA = 1'b1;
    nA  = 16'd13;
    @(negedge clk);
    goA = 1'b0;
    doCheck("ignored_ready", {31'd0, readyA}, 32'd1);
    repeat (5) @(negedge clk);
    doCheck("ignored_ready_later", {31'd0, readyA}, 32'd1);
    doCheck("ignored_factor", {16'd0, factorA}, 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    doCheck("clr_error",  {31'd0, errorA}, 32'd0);
    doCheck("clr_ready",  {31'd0, readyA}, 32'd1);
    doCheck("clr_factor", {16'd0, factorA}, 32'd0);

    $display("[TB] reset mid-computation");
    applyStimulus(0, 65521);
    repeat (50) @(negedge clk);
    doCheck("mid_busy", {31'd0, readyA}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sbQ.pop_front());
    doCheck("mid_ready",  {31'd0, readyA}, 32'd1);
    doCheck("mid_error",  {31'd0, errorA}, 32'd0);
    doCheck("mid_prime",  {31'd0, primeA}, 32'd0);
    doCheck("mid_factor", {16'd0, factorA}, 32'd0);
    applyStimulus(0, 13);
    checkOutput(0, "n13", waited);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
